// File: rtl/mdio_responder.sv
// mdio_responder: PHY-side decoder for the 32-bit MDIO management frame.
// MDC is oversampled on clk; bits are taken on MDC rise, responder drive
// changes on MDC fall. Writes go to a local register file through a one-clk
// strobe, reads return REG_RD_DATA captured once per frame.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        MDIO_IN_OE,
  output logic [4:0]  REG_ADDR,
  output logic [15:0] REG_WR_DATA,
  output logic        REG_WR_STB,
  input  logic [15:0] REG_RD_DATA,
  output logic        BUSY,
  output logic        FRAME_ERR
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    HEADER,
    TA,
    WR_DATA,
    RD_DATA,
    SKIP
  } state_e;

  state_e      state_q, state_d;
  logic        mdc_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [14:0] shift_q, shift_d;
  logic [15:0] rdShift_q, rdShift_d;
  logic        isRead_q, isRead_d;
  logic        rdLast_q, rdLast_d;
  logic        mdioIn_q, mdioIn_d;
  logic        mdioInOe_q, mdioInOe_d;
  logic [4:0]  regAddr_q, regAddr_d;
  logic [15:0] wrData_q, wrData_d;
  logic        wrStb_q, wrStb_d;
  logic        busy_q, busy_d;
  logic        frameErr_q, frameErr_d;

  logic        rise;
  logic        fall;
  logic [1:0]  lastTwo;
  logic [14:0] shiftIn;

  assign rise    = MDC & ~mdc_q;
  assign fall    = ~MDC & mdc_q;
  // previous sampled bit and the bit on the wire right now (OP or TA pair)
  assign lastTwo = {shift_q[0], MDIO_OUT};
  assign shiftIn = {shift_q[13:0], MDIO_OUT};

  // State and output registers; reset forces every output low immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mdc_q      <= 1'b0;
      cnt_q      <= 5'd0;
      shift_q    <= 15'd0;
      rdShift_q  <= 16'd0;
      isRead_q   <= 1'b0;
      rdLast_q   <= 1'b0;
      mdioIn_q   <= 1'b0;
      mdioInOe_q <= 1'b0;
      regAddr_q  <= 5'd0;
      wrData_q   <= 16'd0;
      wrStb_q    <= 1'b0;
      busy_q     <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mdc_q      <= MDC;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rdShift_q  <= rdShift_d;
      isRead_q   <= isRead_d;
      rdLast_q   <= rdLast_d;
      mdioIn_q   <= mdioIn_d;
      mdioInOe_q <= mdioInOe_d;
      regAddr_q  <= regAddr_d;
      wrData_q   <= wrData_d;
      wrStb_q    <= wrStb_d;
      busy_q     <= busy_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Frame decoder: cnt_q holds the index of the next bit expected on a rise.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rdShift_d  = rdShift_q;
    isRead_d   = isRead_q;
    rdLast_d   = rdLast_q;
    mdioIn_d   = mdioIn_q;
    mdioInOe_d = mdioInOe_q;
    regAddr_d  = regAddr_q;
    wrData_d   = wrData_q;
    wrStb_d    = 1'b0;
    busy_d     = busy_q;
    frameErr_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = 5'd0;
        rdLast_d = 1'b0;
        if (rise && MDIO_OE && !MDIO_OUT) begin
          state_d = START;
          cnt_d   = 5'd1;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (rise && MDIO_OUT) begin
          state_d = HEADER;
          cnt_d   = 5'd2;
        end
      end

      HEADER: begin
        if (rise) begin
          shift_d = shiftIn;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd3) begin
            if (lastTwo == 2'b01) begin
              isRead_d = 1'b0;
            end else if (lastTwo == 2'b10) begin
              isRead_d = 1'b1;
            end else begin
              frameErr_d = 1'b1;
              state_d    = SKIP;
            end
          end else if (cnt_q == 5'd13) begin
            regAddr_d = {shift_q[3:0], MDIO_OUT};
            if (shift_q[8:4] != PHY_ADDR) begin
              state_d = SKIP;
            end else begin
              state_d = TA;
            end
          end
        end
      end

      TA: begin
        if (rise) begin
          shift_d = shiftIn;
          cnt_d   = cnt_q + 5'd1;
          if (cnt_q == 5'd15 && !isRead_q) begin
            if (lastTwo == 2'b10) begin
              state_d = WR_DATA;
            end else begin
              frameErr_d = 1'b1;
              state_d    = SKIP;
            end
          end
        end else if (fall && isRead_q && cnt_q == 5'd15) begin
          rdShift_d  = REG_RD_DATA;
          mdioInOe_d = 1'b1;
          mdioIn_d   = 1'b0;
          state_d    = RD_DATA;
        end
      end

      WR_DATA: begin
        if (rise) begin
          shift_d = shiftIn;
          if (cnt_q == 5'd31) begin
            wrData_d = {shift_q, MDIO_OUT};
            wrStb_d  = 1'b1;
            busy_d   = 1'b0;
            cnt_d    = 5'd0;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      RD_DATA: begin
        if (rise) begin
          if (cnt_q == 5'd31) begin
            rdLast_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end else if (fall) begin
          if (rdLast_q) begin
            mdioInOe_d = 1'b0;
            mdioIn_d   = 1'b0;
            busy_d     = 1'b0;
            rdLast_d   = 1'b0;
            cnt_d      = 5'd0;
            state_d    = IDLE;
          end else begin
            mdioIn_d  = rdShift_q[15];
            rdShift_d = {rdShift_q[14:0], 1'b0};
          end
        end
      end

      SKIP: begin
        if (rise) begin
          if (cnt_q == 5'd31) begin
            busy_d  = 1'b0;
            cnt_d   = 5'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign MDIO_IN     = mdioIn_q;
  assign MDIO_IN_OE  = mdioInOe_q;
  assign REG_ADDR    = regAddr_q;
  assign REG_WR_DATA = wrData_q;
  assign REG_WR_STB  = wrStb_q;
  assign BUSY        = busy_q;
  assign FRAME_ERR   = frameErr_q;

endmodule
